// File: rtl/base_decode_sb_if.sv
// Handshake bundle between the way allocator (master), the scoreboarded decoder
// (slave) and the per-way engines that return done pulses.
interface base_decode_sb_if #(
  parameter int enc_width = 3,
  parameter int dec_width = 6
);
  logic                 i_v;
  logic                 o_r;
  logic [enc_width-1:0] i_d;
  logic                 o_v;
  logic                 i_r;
  logic [dec_width-1:0] o_d;
  logic [dec_width-1:0] i_done;
  logic [dec_width-1:0] o_busy;
  logic                 o_err;

  modport master (
    output i_v, i_d, i_r, i_done,
    input  o_r, o_v, o_d, o_busy, o_err
  );

  modport slave (
    input  i_v, i_d, i_r, i_done,
    output o_r, o_v, o_d, o_busy, o_err
  );
endinterface

// File: rtl/base_decode.sv
// Combinational binary-to-one-hot decoder; indices at or above dec_width yield all zeros.
module base_decode #(
  parameter int enc_width = 3,
  parameter int dec_width = 6
) (
  input  logic [enc_width-1:0] idx,
  output logic [dec_width-1:0] onehot
);
  always_comb begin
    onehot = '0;
    for (int k = 0; k < dec_width; k++) begin
      if (idx == enc_width'(k)) onehot[k] = 1'b1;
    end
  end
endmodule

// File: rtl/base_decode_sb.sv
// Scoreboarded index-to-one-hot issuer: 2-entry FIFO, in-order head, 1-cycle accept-to-issue.
// Upstream ready depends only on FIFO occupancy; a head whose way is busy stalls everything behind it.
module base_decode_sb #(
  parameter int enc_width = 3,
  parameter int dec_width = 6
) (
  input logic            clk,
  input logic            reset,
  base_decode_sb_if.slave bus
);
  logic [enc_width-1:0] mem [2];
  logic [1:0]           count;
  logic                 head;
  logic                 tail;
  logic [dec_width-1:0] busy;
  logic                 err;

  logic [dec_width-1:0] head_dec;
  logic                 in_range;
  logic                 push;
  logic                 wr;
  logic                 pop;
  logic                 head_busy;
  logic                 vld;

  base_decode #(
    .enc_width(enc_width),
    .dec_width(dec_width)
  ) u_dec (
    .idx   (mem[head]),
    .onehot(head_dec)
  );

  // Out-of-range indices still complete the handshake but never enter the FIFO.
  assign in_range  = ({{(32-enc_width){1'b0}}, bus.i_d} < 32'(dec_width));
  assign bus.o_r   = (count != 2'd2);
  assign push      = bus.i_v & bus.o_r;
  assign wr        = push & in_range;

  assign head_busy = |(busy & head_dec);
  assign vld       = (count != 2'd0) & ~head_busy;
  assign pop       = vld & bus.i_r;

  assign bus.o_v    = vld;
  assign bus.o_d    = vld ? head_dec : '0;
  assign bus.o_busy = busy;
  assign bus.o_err  = err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      busy   <= '0;
      err    <= 1'b0;
    end else begin
      if (wr) begin
        mem[tail] <= bus.i_d;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, wr} - {1'b0, pop};
      err   <= push & ~in_range;
      // A done arriving for an idle way in its own issue cycle loses to the set.
      busy  <= (busy & ~bus.i_done) | (pop ? head_dec : '0);
    end
  end
endmodule

// File: tb/tb_base_decode_sb.sv
module tb_base_decode_sb;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  base_decode_sb_if #(.enc_width(3), .dec_width(6)) bus ();

  base_decode_sb #(.enc_width(3), .dec_width(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] d;
    logic       r;
    logic [5:0] done;
    logic       exp_or;
    logic       exp_ov;
    logic [5:0] exp_od;
    logic [5:0] exp_busy;
    logic       exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [2:0] d, input logic r, input logic [5:0] done,
                     input logic eor, input logic eov, input logic [5:0] eod,
                     input logic [5:0] ebusy, input logic eerr);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.done = done;
    t.exp_or = eor; t.exp_ov = eov; t.exp_od = eod; t.exp_busy = ebusy; t.exp_err = eerr;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] d, input logic r, input logic [5:0] done);
    bus.i_v = v; bus.i_d = d; bus.i_r = r; bus.i_done = done;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 6'd0);

    // Columns: i_v i_d i_r i_done | o_r o_v o_d o_busy o_err (values seen before the edge)
    // basic issue of way 2
    add(1, 3'd2, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 1, 6'b000100, 6'b000000, 0);
    add(0, 3'd0, 0, 6'b000000,  1, 0, 6'b000000, 6'b000100, 0);
    add(0, 3'd0, 0, 6'b000100,  1, 0, 6'b000000, 6'b000100, 0);
    add(0, 3'd0, 0, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    // busy block on way 3, then in-order release
    add(1, 3'd3, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 1, 6'b001000, 6'b000000, 0);
    add(1, 3'd3, 1, 6'b000000,  1, 0, 6'b000000, 6'b001000, 0);
    add(1, 3'd1, 1, 6'b000000,  1, 0, 6'b000000, 6'b001000, 0);
    add(0, 3'd0, 1, 6'b001000,  0, 0, 6'b000000, 6'b001000, 0);
    add(0, 3'd0, 1, 6'b000000,  0, 1, 6'b001000, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 1, 6'b000010, 6'b001000, 0);
    add(0, 3'd0, 0, 6'b001010,  1, 0, 6'b000000, 6'b001010, 0);
    add(0, 3'd0, 0, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    // out-of-range 7 and 6 are dropped with a one-cycle error
    add(1, 3'd7, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 1);
    add(1, 3'd6, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 1);
    add(0, 3'd0, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    // fill under backpressure; third push refused
    add(1, 3'd0, 0, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    add(1, 3'd1, 0, 6'b000000,  1, 1, 6'b000001, 6'b000000, 0);
    add(1, 3'd2, 0, 6'b000000,  0, 1, 6'b000001, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  0, 1, 6'b000001, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 1, 6'b000010, 6'b000001, 0);
    add(0, 3'd0, 0, 6'b000011,  1, 0, 6'b000000, 6'b000011, 0);
    // simultaneous push and pop at count 1
    add(1, 3'd4, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    add(1, 3'd5, 1, 6'b000000,  1, 1, 6'b010000, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 1, 6'b100000, 6'b010000, 0);
    add(0, 3'd0, 0, 6'b010000,  1, 0, 6'b000000, 6'b110000, 0);
    // ways 0 and 5 busy; spurious done then multi-bit done
    add(1, 3'd0, 1, 6'b000000,  1, 0, 6'b000000, 6'b100000, 0);
    add(0, 3'd0, 1, 6'b000000,  1, 1, 6'b000001, 6'b100000, 0);
    add(0, 3'd0, 0, 6'b000100,  1, 0, 6'b000000, 6'b100001, 0);
    add(0, 3'd0, 0, 6'b100001,  1, 0, 6'b000000, 6'b100001, 0);
    add(0, 3'd0, 0, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    // done for an idle way in its own issue cycle: set wins
    add(1, 3'd2, 1, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);
    add(0, 3'd0, 1, 6'b000100,  1, 1, 6'b000100, 6'b000000, 0);
    add(0, 3'd0, 0, 6'b000000,  1, 0, 6'b000000, 6'b000100, 0);
    add(0, 3'd0, 0, 6'b000100,  1, 0, 6'b000000, 6'b000100, 0);
    add(0, 3'd0, 0, 6'b000000,  1, 0, 6'b000000, 6'b000000, 0);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_r", 32'(bus.o_r), 32'd1);
    chk("rst_o_v", 32'(bus.o_v), 32'd0);
    chk("rst_o_d", 32'(bus.o_d), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_err", 32'(bus.o_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // reset mid-stream: way 1 busy, entries 2 and 4 queued
    @(negedge clk); drive(1'b1, 3'd1, 1'b1, 6'd0);
    @(negedge clk); drive(1'b0, 3'd0, 1'b1, 6'd0);
    #1; chk("mid_issue1_v", 32'(bus.o_v), 32'd1);
    @(negedge clk); drive(1'b1, 3'd2, 1'b0, 6'd0);
    #1; chk("mid_busy1", 32'(bus.o_busy), 32'b000010);
    @(negedge clk); drive(1'b1, 3'd4, 1'b0, 6'd0);
    @(negedge clk); drive(1'b0, 3'd0, 1'b0, 6'd0);
    #1; chk("mid_full_o_r", 32'(bus.o_r), 32'd0);
    chk("mid_head_od", 32'(bus.o_d), 32'b000100);
    #1; reset = 1'b1;
    #1;
    chk("mid_rst_o_v", 32'(bus.o_v), 32'd0);
    chk("mid_rst_o_r", 32'(bus.o_r), 32'd1);
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("mid_rst_o_d", 32'(bus.o_d), 32'd0);
    @(negedge clk); reset = 1'b0; drive(1'b0, 3'd0, 1'b1, 6'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_rst_o_v", 32'(bus.o_v), 32'd0);
      chk("post_rst_err", 32'(bus.o_err), 32'd0);
      chk("post_rst_busy", 32'(bus.o_busy), 32'd0);
    end

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].done);
      #1;
      chk($sformatf("v%0d_o_r", i), 32'(bus.o_r), 32'(tbl[i].exp_or));
      chk($sformatf("v%0d_o_v", i), 32'(bus.o_v), 32'(tbl[i].exp_ov));
      chk($sformatf("v%0d_o_d", i), 32'(bus.o_d), 32'(tbl[i].exp_od));
      chk($sformatf("v%0d_busy", i), 32'(bus.o_busy), 32'(tbl[i].exp_busy));
      chk($sformatf("v%0d_err", i), 32'(bus.o_err), 32'(tbl[i].exp_err));
    end

    @(negedge clk);
    drive(1'b0, 3'd0, 1'b0, 6'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
